// File: rtl/ocp_slave_fsm.sv
// rtl/ocp_slave_fsm.sv - OCP slave with word storage, INCR burst tracking and held responses
module ocp_slave_fsm #(
  parameter int ADDR_WDTH    = 32,
  parameter int DATA_WDTH    = 32,
  parameter int DEPTH        = 16,
  parameter int WRITERESP_EN = 1
) (
  input  logic                   sys_clk,
  input  logic                   reset,
  input  logic [2:0]             MCmd,
  input  logic [ADDR_WDTH-1:0]   MAddr,
  input  logic [DATA_WDTH-1:0]   MData,
  input  logic [DATA_WDTH/8-1:0] MByteEn,
  input  logic [9:0]             MBurstLength,
  input  logic [2:0]             MBurstSeq,
  input  logic                   MReqLast,
  input  logic                   MRespAccept,
  output logic                   SCmdAccept,
  output logic                   SDataAccept,
  output logic [1:0]             SResp,
  output logic [DATA_WDTH-1:0]   SData,
  output logic                   SRespLast
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int BE_W  = DATA_WDTH / 8;

  localparam logic [2:0] CMD_IDLE = 3'b000;
  localparam logic [2:0] CMD_WR   = 3'b001;
  localparam logic [2:0] CMD_RD   = 3'b010;

  localparam logic [1:0] RESP_NULL = 2'b00;
  localparam logic [1:0] RESP_DVA  = 2'b01;
  localparam logic [1:0] RESP_ERR  = 2'b11;

  // One extra bit so the carry out of the address increment shows a wrap.
  localparam logic [ADDR_WDTH:0] ADDR_STEP = (ADDR_WDTH + 1)'(4);

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } state_t;

  // Registered state and outputs.
  state_t                 state_q, state_d;
  logic                   scmd_accept_q, scmd_accept_d;
  logic [1:0]             sresp_q, sresp_d;
  logic [DATA_WDTH-1:0]   sdata_q, sdata_d;
  logic                   sresp_last_q, sresp_last_d;

  // Burst tracking; next_wrap marks that next_addr overflowed the address space.
  logic [9:0]             beats_left_q, beats_left_d;
  logic [ADDR_WDTH-1:0]   next_addr_q, next_addr_d;
  logic                   next_wrap_q, next_wrap_d;
  logic [2:0]             burst_cmd_q, burst_cmd_d;

  // Word storage.
  logic [DATA_WDTH-1:0]   mem_q [DEPTH];
  logic [DATA_WDTH-1:0]   mem_d [DEPTH];

  // Request decode helpers.
  logic [IDX_W-1:0]       word_idx;
  logic [ADDR_WDTH-1:0]   addr_hi;
  logic                   addr_err;
  logic                   is_wr;
  logic                   is_rd;
  logic                   first_beat;
  logic [ADDR_WDTH:0]     addr_inc;
  logic [9:0]             beats_nxt;
  logic [ADDR_WDTH-1:0]   naddr_nxt;
  logic                   wrap_nxt;
  logic                   burst_err;
  logic                   last_beat;
  logic                   req_err;
  logic [DATA_WDTH-1:0]   wr_word;

  assign word_idx = MAddr[IDX_W+1:2];
  assign addr_hi  = MAddr >> (IDX_W + 2);
  assign addr_err = (MAddr[1:0] != 2'b00) || (addr_hi != '0);
  assign is_wr    = (MCmd == CMD_WR);
  assign is_rd    = (MCmd == CMD_RD);

  assign SCmdAccept  = scmd_accept_q;
  assign SDataAccept = scmd_accept_q;
  assign SResp       = sresp_q;
  assign SData       = sdata_q;
  assign SRespLast   = sresp_last_q;

  // Next-state, burst bookkeeping, storage update and response selection.
  always_comb begin
    state_d       = state_q;
    scmd_accept_d = scmd_accept_q;
    sresp_d       = sresp_q;
    sdata_d       = sdata_q;
    sresp_last_d  = sresp_last_q;
    beats_left_d  = beats_left_q;
    next_addr_d   = next_addr_q;
    next_wrap_d   = next_wrap_q;
    burst_cmd_d   = burst_cmd_q;
    mem_d         = mem_q;

    first_beat = (beats_left_q == 10'd0);
    addr_inc   = '0;
    beats_nxt  = '0;
    naddr_nxt  = '0;
    wrap_nxt   = 1'b0;
    burst_err  = 1'b0;
    last_beat  = 1'b0;
    req_err    = 1'b0;
    wr_word    = mem_q[word_idx];

    // Merge only the enabled bytes into the stored word.
    for (int b = 0; b < BE_W; b++) begin
      if (MByteEn[b]) begin
        wr_word[b*8 +: 8] = MData[b*8 +: 8];
      end
    end

    case (state_q)
      ST_IDLE: begin
        // SCmdAccept is held low for the first edge after reset, so gate on it.
        scmd_accept_d = 1'b1;
        if (scmd_accept_q && (MCmd != CMD_IDLE)) begin
          if (first_beat) begin
            addr_inc  = {1'b0, MAddr} + ADDR_STEP;
            beats_nxt = MBurstLength - 10'd1;
            burst_err = (MBurstLength == 10'd0);
          end else begin
            addr_inc  = {1'b0, next_addr_q} + ADDR_STEP;
            beats_nxt = beats_left_q - 10'd1;
            burst_err = (MAddr != next_addr_q) || (MCmd != burst_cmd_q) || next_wrap_q;
          end
          naddr_nxt = addr_inc[ADDR_WDTH-1:0];
          wrap_nxt  = addr_inc[ADDR_WDTH];
          last_beat = (beats_nxt == 10'd0);
          req_err   = !(is_wr || is_rd) || (MBurstSeq != 3'b000) || burst_err ||
                      addr_err || (MReqLast != last_beat);

          if (req_err) begin
            // Any error closes the burst; storage is untouched.
            beats_left_d  = 10'd0;
            state_d       = ST_RESP;
            scmd_accept_d = 1'b0;
            sresp_d       = RESP_ERR;
            sdata_d       = '0;
            sresp_last_d  = 1'b1;
          end else begin
            beats_left_d = beats_nxt;
            next_addr_d  = naddr_nxt;
            next_wrap_d  = wrap_nxt;
            burst_cmd_d  = MCmd;
            if (is_wr) begin
              mem_d[word_idx] = wr_word;
              if (WRITERESP_EN != 0) begin
                state_d       = ST_RESP;
                scmd_accept_d = 1'b0;
                sresp_d       = RESP_DVA;
                sdata_d       = '0;
                sresp_last_d  = last_beat;
              end
            end else begin
              state_d       = ST_RESP;
              scmd_accept_d = 1'b0;
              sresp_d       = RESP_DVA;
              sdata_d       = mem_q[word_idx];
              sresp_last_d  = last_beat;
            end
          end
        end
      end

      ST_RESP: begin
        // Response is held until the master takes it.
        if (MRespAccept) begin
          state_d       = ST_IDLE;
          scmd_accept_d = 1'b1;
          sresp_d       = RESP_NULL;
          sdata_d       = '0;
          sresp_last_d  = 1'b0;
        end
      end

      default: begin
        state_d       = ST_IDLE;
        scmd_accept_d = 1'b0;
        sresp_d       = RESP_NULL;
        sdata_d       = '0;
        sresp_last_d  = 1'b0;
      end
    endcase
  end

  // FSM, registered outputs, burst registers and storage; reset clears everything.
  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      scmd_accept_q <= 1'b0;
      sresp_q       <= RESP_NULL;
      sdata_q       <= '0;
      sresp_last_q  <= 1'b0;
      beats_left_q  <= '0;
      next_addr_q   <= '0;
      next_wrap_q   <= 1'b0;
      burst_cmd_q   <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      state_q       <= state_d;
      scmd_accept_q <= scmd_accept_d;
      sresp_q       <= sresp_d;
      sdata_q       <= sdata_d;
      sresp_last_q  <= sresp_last_d;
      beats_left_q  <= beats_left_d;
      next_addr_q   <= next_addr_d;
      next_wrap_q   <= next_wrap_d;
      burst_cmd_q   <= burst_cmd_d;
      mem_q         <= mem_d;
    end
  end

endmodule

// File: tb/tb_ocp_slave_fsm.sv
// tb/tb_ocp_slave_fsm.sv - directed self-checking bench for ocp_slave_fsm
module tb_ocp_slave_fsm;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic [2:0]  MCmd;
  logic [31:0] MAddr;
  logic [31:0] MData;
  logic [3:0]  MByteEn;
  logic [9:0]  MBurstLength;
  logic [2:0]  MBurstSeq;
  logic        MReqLast;
  logic        MRespAccept;

  logic        SCmdAccept, SDataAccept, SRespLast;
  logic [1:0]  SResp;
  logic [31:0] SData;

  logic        SCmdAccept0, SDataAccept0, SRespLast0;
  logic [1:0]  SResp0;
  logic [31:0] SData0;

  int checks = 0;
  int errors = 0;

  always #5 sys_clk = ~sys_clk;

  ocp_slave_fsm dut (
    .sys_clk(sys_clk), .reset(reset), .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
    .MByteEn(MByteEn), .MBurstLength(MBurstLength), .MBurstSeq(MBurstSeq),
    .MReqLast(MReqLast), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept),
    .SDataAccept(SDataAccept), .SResp(SResp), .SData(SData), .SRespLast(SRespLast)
  );

  ocp_slave_fsm #(.WRITERESP_EN(0)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .MCmd(MCmd), .MAddr(MAddr), .MData(MData),
    .MByteEn(MByteEn), .MBurstLength(MBurstLength), .MBurstSeq(MBurstSeq),
    .MReqLast(MReqLast), .MRespAccept(MRespAccept), .SCmdAccept(SCmdAccept0),
    .SDataAccept(SDataAccept0), .SResp(SResp0), .SData(SData0), .SRespLast(SRespLast0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge sys_clk);
    @(negedge sys_clk);
  endtask

  // Present one request at a negedge, let the next posedge take it, then idle MCmd.
  task automatic xact(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                      input logic [3:0] be, input logic [9:0] blen, input logic rlast);
    MCmd = cmd; MAddr = addr; MData = data; MByteEn = be; MBurstLength = blen; MReqLast = rlast;
    cyc();
    MCmd = 3'b000;
  endtask

  task automatic release_resp();
    MRespAccept = 1'b1;
    cyc();
    MRespAccept = 1'b0;
  endtask

  task automatic resp_ok(input string tag);
    release_resp();
    chk({tag, "_resp_null"}, {30'd0, SResp}, 32'h0);
    chk({tag, "_accept"}, {31'd0, SCmdAccept}, 32'h1);
  endtask

  task automatic check_resp(input string tag, input logic [1:0] resp, input logic [31:0] data,
                            input logic last);
    chk({tag, "_sresp"}, {30'd0, SResp}, {30'd0, resp});
    chk({tag, "_sdata"}, SData, data);
    chk({tag, "_last"}, {31'd0, SRespLast}, {31'd0, last});
  endtask

  initial begin
    reset = 1'b1; MCmd = 3'b000; MAddr = '0; MData = '0; MByteEn = '0;
    MBurstLength = '0; MBurstSeq = 3'b000; MReqLast = 1'b0; MRespAccept = 1'b0;
    repeat (3) @(negedge sys_clk);

    chk("rst_cmd_accept", {31'd0, SCmdAccept}, 32'h0);
    chk("rst_data_accept", {31'd0, SDataAccept}, 32'h0);
    check_resp("rst", 2'b00, 32'h0, 1'b0);

    reset = 1'b0;
    #1 chk("rel_accept_low", {31'd0, SCmdAccept}, 32'h0);
    @(negedge sys_clk);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rel_accept_high", {31'd0, SCmdAccept}, 32'h1);
    chk("rel_data_accept", {31'd0, SDataAccept}, 32'h1);

    // Write then read back a full word.
    xact(3'b001, 32'h4, 32'hDEADBEEF, 4'hF, 10'd1, 1'b1);
    check_resp("wr4", 2'b01, 32'h0, 1'b1);
    chk("wr4_accept_low", {31'd0, SCmdAccept}, 32'h0);
    resp_ok("wr4");
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("rd4", 2'b01, 32'hDEADBEEF, 1'b1);
    resp_ok("rd4");

    // Partial byte-enable write.
    xact(3'b001, 32'h8, 32'hFFFFFFFF, 4'hF, 10'd1, 1'b1);
    resp_ok("wr8a");
    xact(3'b001, 32'h8, 32'h00000000, 4'h3, 10'd1, 1'b1);
    resp_ok("wr8b");
    xact(3'b010, 32'h8, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("rd8", 2'b01, 32'hFFFF0000, 1'b1);
    resp_ok("rd8");

    // Four-beat read burst with beat 2 held for 3 cycles.
    xact(3'b010, 32'h0, 32'h0, 4'h0, 10'd4, 1'b0);
    check_resp("bst1", 2'b01, 32'h0, 1'b0);
    resp_ok("bst1");
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd4, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_resp("bst2_hold", 2'b01, 32'hDEADBEEF, 1'b0);
      chk("bst2_hold_accept", {31'd0, SCmdAccept}, 32'h0);
      cyc();
    end
    check_resp("bst2", 2'b01, 32'hDEADBEEF, 1'b0);
    resp_ok("bst2");
    xact(3'b010, 32'h8, 32'h0, 4'h0, 10'd4, 1'b0);
    check_resp("bst3", 2'b01, 32'hFFFF0000, 1'b0);
    resp_ok("bst3");
    xact(3'b010, 32'hC, 32'h0, 4'h0, 10'd4, 1'b1);
    check_resp("bst4", 2'b01, 32'h0, 1'b1);
    resp_ok("bst4");

    // Error cases.
    xact(3'b010, 32'h40, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("err_range", 2'b11, 32'h0, 1'b1);
    resp_ok("err_range");
    xact(3'b010, 32'h6, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("err_align", 2'b11, 32'h0, 1'b1);
    resp_ok("err_align");
    xact(3'b011, 32'h4, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("err_cmd", 2'b11, 32'h0, 1'b1);
    resp_ok("err_cmd");
    MBurstSeq = 3'b001;
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd1, 1'b1);
    MBurstSeq = 3'b000;
    check_resp("err_seq", 2'b11, 32'h0, 1'b1);
    resp_ok("err_seq");
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd0, 1'b1);
    check_resp("err_blen0", 2'b11, 32'h0, 1'b1);
    resp_ok("err_blen0");
    xact(3'b010, 32'h0, 32'h0, 4'h0, 10'd1, 1'b0);
    check_resp("err_reqlast", 2'b11, 32'h0, 1'b1);
    resp_ok("err_reqlast");
    xact(3'b001, 32'h5, 32'h12345678, 4'hF, 10'd1, 1'b1);
    check_resp("err_wr", 2'b11, 32'h0, 1'b1);
    resp_ok("err_wr");
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("err_wr_nochg", 2'b01, 32'hDEADBEEF, 1'b1);
    resp_ok("err_wr_nochg");

    // Burst aborted on beat 2, next request opens a fresh burst.
    xact(3'b010, 32'h0, 32'h0, 4'h0, 10'd2, 1'b0);
    check_resp("abort_b1", 2'b01, 32'h0, 1'b0);
    resp_ok("abort_b1");
    xact(3'b010, 32'h10, 32'h0, 4'h0, 10'd2, 1'b1);
    check_resp("abort_b2", 2'b11, 32'h0, 1'b1);
    resp_ok("abort_b2");
    xact(3'b010, 32'h8, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("abort_new", 2'b01, 32'hFFFF0000, 1'b1);
    resp_ok("abort_new");

    // Reset pulse while a response is pending.
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("pre_rst", 2'b01, 32'hDEADBEEF, 1'b1);
    reset = 1'b1;
    #1;
    check_resp("mid_rst", 2'b00, 32'h0, 1'b0);
    chk("mid_rst_accept", {31'd0, SCmdAccept}, 32'h0);
    @(negedge sys_clk);
    reset = 1'b0;
    #1 chk("rst2_accept_low", {31'd0, SCmdAccept}, 32'h0);
    @(posedge sys_clk);
    @(negedge sys_clk);
    chk("rst2_accept_high", {31'd0, SCmdAccept}, 32'h1);
    xact(3'b010, 32'h4, 32'h0, 4'h0, 10'd1, 1'b1);
    check_resp("rst2_rd4", 2'b01, 32'h0, 1'b1);
    release_resp();

    // Posted writes on the instance without write responses.
    for (int i = 0; i < 4; i++) begin
      chk("nr_accept", {31'd0, SCmdAccept0}, 32'h1);
      chk("nr_sresp", {30'd0, SResp0}, 32'h0);
      MCmd = 3'b001; MAddr = 32'(i * 4); MData = 32'hA0A0_0000 + 32'(i);
      MByteEn = 4'hF; MBurstLength = 10'd1; MReqLast = 1'b1;
      cyc();
    end
    MCmd = 3'b000;
    chk("nr_accept_end", {31'd0, SCmdAccept0}, 32'h1);
    chk("nr_sresp_end", {30'd0, SResp0}, 32'h0);
    for (int i = 0; i < 4; i++) begin
      xact(3'b010, 32'(i * 4), 32'h0, 4'h0, 10'd1, 1'b1);
      chk("nr_rd_sresp", {30'd0, SResp0}, 32'h1);
      chk("nr_rd_sdata", SData0, 32'hA0A0_0000 + 32'(i));
      release_resp();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/ocp_slave_fsm.md
OCP_SLAVE_FSM -- requirements
Module: ocp_slave_fsm

Interface
REQ-001 Parameters SHALL be: ADDR_WDTH, 32, MAddr width; DATA_WDTH, 32, data width; DEPTH, 16, words of internal storage (power of 2); WRITERESP_EN, 1, writes produce responses when 1.
REQ-002 The block SHALL use one clock; reset is asynchronous and active-high.
REQ-003 Ports SHALL be:
- sys_clk  in  1  clock, rising edge.
- reset  in  1  asynchronous active-high reset.
- MCmd  in  3  000 IDLE, 001 WR, 010 RD, others unsupported.
- MAddr  in  ADDR_WDTH  byte address.
- MData  in  DATA_WDTH  write data, valid with the WR request.
- MByteEn  in  DATA_WDTH/8  write byte enables.
- MBurstLength  in  10  beats in burst.
- MBurstSeq  in  3  000 INCR; others unsupported.
- MReqLast  in  1  last request of burst.
- MRespAccept  in  1  master accepts response.
- SCmdAccept  out  1  request accepted.
- SDataAccept  out  1  equals SCmdAccept.
- SResp  out  2  00 NULL, 01 DVA, 11 ERR.
- SData  out  DATA_WDTH  read data.
- SRespLast  out  1  last response of burst.

Function
REQ-004 The FSM SHALL have states IDLE (SCmdAccept=1) and RESP (SCmdAccept=0, response driven); all outputs SHALL be registered.
REQ-005 A request SHALL be accepted on a rising edge where state is IDLE and MCmd!=000.
REQ-006 An accepted RD, or an accepted WR with WRITERESP_EN=1, SHALL move to RESP and drive SResp the next cycle.
REQ-007 In RESP, SResp, SData and SRespLast SHALL be held stable until an edge with MRespAccept=1. At that edge SResp SHALL go to 00 and the state to IDLE.
REQ-008 Minimum spacing for responded transactions SHALL be 2 cycles (accept, response with MRespAccept=1, accept).
REQ-009 An accepted WR with WRITERESP_EN=0 SHALL stay in IDLE, allowing one write per cycle.
REQ-010 Word index SHALL be MAddr[log2(DEPTH)+1:2].
- Error if MAddr[1:0]!=0 or MAddr >= 4*DEPTH.
- An error SHALL give SResp=11, SData=0, and no storage change.
REQ-011 WR SHALL update only bytes whose MByteEn bit is 1. RD SHALL ignore MByteEn and return the full word with SResp=01.
REQ-012 Unsupported MCmd or MBurstSeq!=000 SHALL give SResp=11. A WR error SHALL give ERR even when WRITERESP_EN=0.
REQ-013 Burst tracking SHALL use beats_left (10 bits, 0 = no burst open), next_addr and burst_cmd.
REQ-014 On the first beat (beats_left=0):
- MBurstLength=0 SHALL give ERR.
- Otherwise load beats_left=MBurstLength-1, next_addr=MAddr+4, burst_cmd=MCmd.
REQ-015 On later beats:
- MAddr!=next_addr or MCmd!=burst_cmd SHALL give ERR and clear beats_left (burst aborted).
- Otherwise decrement beats_left and add 4 to next_addr.
REQ-016 SRespLast SHALL be 1 when beats_left is 0 after the beat, and on every ERR.
- MReqLast not matching that condition SHALL give ERR.
REQ-017 next_addr SHALL wrap modulo 2^ADDR_WDTH. A wrapped address SHALL fail the range check.
REQ-018 MCmd=000 SHALL never change burst state.

Reset
REQ-019 While reset=1:
- state = IDLE, with SCmdAccept=SDataAccept=0.
- SResp=00, SData=0, SRespLast=0.
- beats_left=0, next_addr=0, burst_cmd=0, storage cleared to 0.
REQ-020 SCmdAccept SHALL rise on the first edge after reset falls.
REQ-021 Reset asserted in RESP SHALL abandon the response immediately, with no partial write retained beyond the accepted beat.

Verification
REQ-022 WR 0x4 data 0xDEADBEEF MByteEn=0xF, then RD 0x4 -> SResp=01 for the write and for the read, SData=0xDEADBEEF, SRespLast=1.
REQ-023 WR 0x8 0xFFFFFFFF, then WR 0x8 0x00000000 MByteEn=0x3, then RD 0x8 -> SData=0xFFFF0000.
REQ-024 RD burst MBurstLength=4 at 0x0,0x4,0x8,0xC with MRespAccept held low 3 cycles on beat 2 -> 4 DVA responses, SRespLast only on beat 4, beat-2 outputs stable while held.
REQ-025 Error cases:
- RD 0x40 (DEPTH=16) -> ERR.
- RD 0x6 -> ERR.
- MCmd=011 -> ERR.
- Burst beat 2 at 0x10 instead of 0x4 -> ERR, SRespLast=1, next request treated as a new burst.
REQ-026 Reset pulse while in RESP -> SResp=00 and SCmdAccept=0 immediately; SCmdAccept=1 one edge after release; RD 0x4 then returns 0.
REQ-027 WRITERESP_EN=0, 4 back-to-back WR in consecutive cycles -> SCmdAccept stays 1 and SResp stays 00 throughout; all 4 words stored.
